// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcode encoding, flag bit positions, FSM states.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } opcode_t;

    // Bit positions inside the 5-bit Flags word {N,Z,C,V,P}.
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier for alu_seq. The first partial product is added on the
// start edge, the remaining M-1 on the following cycles; done pulses for one
// cycle once product holds the full 2M-bit result.
module alu_seq_mul #(
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [M-1:0]   A,
    input  logic [M-1:0]   B,
    output logic           busy,
    output logic           done,
    output logic [2*M-1:0] product
);

    localparam int CW = $clog2(M);

    logic [2*M-1:0] mcand;
    logic [M-1:0]   mplier;
    logic [CW-1:0]  count;

    // Load operands on start, then one conditional add and shift per cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            // NOTE: datapath registers reset too, so an aborted multiply leaves no stale product.
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= B[0] ? {{M{1'b0}}, A} : '0;
                mcand   <= {{M{1'b0}}, A} << 1;
                mplier  <= B >> 1;
                count   <= CW'(1);
                busy    <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (count == CW'(M - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 8-op ALU with valid/ready handshakes and registered Result/Flags.
// Define ALU_MUL_EN to compile in the multi-cycle multiplier (OpCode 111);
// without it OpCode 111 completes in one cycle with Result=0.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic [2:0]   OpCode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] Result,
    output logic [4:0]   Flags
);

    localparam int SW = $clog2(M);

    state_t         state, state_next;
    logic           accept;
    logic           load_result;
    logic [M-1:0]   alu_result, result_next;
    logic [4:0]     alu_flags, flags_next;
    logic [M:0]     add_ext, sub_ext, shl_ext, shr_ext;
    logic [SW-1:0]  sh;

    function automatic logic [4:0] make_flags(input logic [M-1:0] r, input logic c, input logic v);
        logic [4:0] f;
        f         = '0;
        f[FLAG_N] = r[M-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_P] = ^r;
        return f;
    endfunction

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Widened arithmetic: the extra bit carries carry/borrow or the shifted-out bit.
    assign sh      = B[SW-1:0];
    assign add_ext = {1'b0, A} + {1'b0, B};
    assign sub_ext = {1'b0, A} - {1'b0, B};
    assign shl_ext = {1'b0, A} << sh;
    assign shr_ext = {A, 1'b0} >> sh;

`ifdef ALU_MUL_EN
    logic           mul_start, mul_busy, mul_done;
    logic [2*M-1:0] mul_product;
    logic           mul_high;

    assign mul_start = accept && (OpCode == OP_MUL) && !mul_busy;
    assign mul_high  = (mul_product[2*M-1:M] != '0);

    alu_seq_mul #(.M(M)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle operations and their flags, computed from the live operands at accept.
    always_comb begin
        logic c, v;
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        alu_result = '0;
        c          = 1'b0;
        v          = 1'b0;
        case (opcode_t'(OpCode))
            OP_ADD: begin
                alu_result = add_ext[M-1:0];
                c          = add_ext[M];
                v          = (A[M-1] == B[M-1]) && (add_ext[M-1] != A[M-1]);
            end
            OP_SUB: begin
                alu_result = sub_ext[M-1:0];
                c          = sub_ext[M];
                v          = (A[M-1] != B[M-1]) && (sub_ext[M-1] != A[M-1]);
            end
            OP_OR:  alu_result = A | B;
            OP_AND: alu_result = A & B;
            OP_XOR: alu_result = A ^ B;
            OP_SHL: begin
                alu_result = shl_ext[M-1:0];
                c          = shl_ext[M];
            end
            OP_SHR: begin
                alu_result = shr_ext[M:1];
                c          = shr_ext[0];
            end
            default: alu_result = '0;
        endcase
        alu_flags = make_flags(alu_result, c, v);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and selection of the value to register into Result/Flags.
    always_comb begin
        state_next  = state;
        load_result = 1'b0;
        result_next = alu_result;
        flags_next  = alu_flags;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (OpCode == OP_MUL) begin
                        state_next = MUL;
                    end else begin
                        load_result = 1'b1;
                        state_next  = DONE;
                    end
`else
                    load_result = 1'b1;
                    state_next  = DONE;
`endif
                end
            end
            MUL: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    result_next = mul_product[M-1:0];
                    flags_next  = make_flags(mul_product[M-1:0], mul_high, mul_high);
                    load_result = 1'b1;
                    state_next  = DONE;
                end
`else
                state_next = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result/Flags hold their value until the next completed operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            Result <= '0;
            Flags  <= '0;
        end else if (load_result) begin
            Result <= result_next;
            Flags  <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at M=4. MUL scenarios run when ALU_MUL_EN is
// defined; otherwise the single-cycle OpCode 111 behaviour is checked.
module tb_alu_seq;

    localparam int M = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a, b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] result;
    logic [4:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic [4:0] fl;
    } vec_t;

    // Flags are {N,Z,C,V,P}.
    vec_t vecs [12] = '{
        '{4'hF, 4'h1, 3'b000, 4'h0, 5'b01100},   // ADD carry out, zero
        '{4'hF, 4'h1, 3'b001, 4'hE, 5'b10001},   // SUB
        '{4'h7, 4'h1, 3'b000, 4'h8, 5'b10011},   // ADD signed overflow
        '{4'h1, 4'h2, 3'b001, 4'hF, 5'b10100},   // SUB borrow
        '{4'h8, 4'h1, 3'b001, 4'h7, 5'b00011},   // SUB signed overflow
        '{4'hA, 4'h5, 3'b010, 4'hF, 5'b10000},   // OR
        '{4'hC, 4'hA, 3'b011, 4'h8, 5'b10001},   // AND
        '{4'hC, 4'hC, 3'b100, 4'h0, 5'b01000},   // XOR to zero
        '{4'hB, 4'h1, 3'b101, 4'h6, 5'b00100},   // SHL by 1, bit out
        '{4'h3, 4'hC, 3'b101, 4'h3, 5'b00000},   // SHL upper B ignored, amount 0
        '{4'hB, 4'h2, 3'b110, 4'h2, 5'b00101},   // SHR by 2
        '{4'h9, 4'h3, 3'b110, 4'h1, 5'b00001}    // SHR by 3, bit out 0
    };

    alu_seq #(.M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .OpCode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (result),
        .Flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for a single cycle, scramble inputs, count cycles to out_valid.
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] op,
                          output int lat);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        opcode   = op;
        tick();
        in_valid = 1'b0;
        a        = ~ia;
        b        = 4'($urandom);
        opcode   = op ^ 3'b101;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        opcode    = '0;
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready: got %b expected 0", in_ready); n_bad++; end
        n_cmp++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_bad++; end
        n_cmp++;
        if (result !== 4'h0 || flags !== 5'b0) begin
            $display("FAIL reset_outputs: got %h/%b expected 0/00000", result, flags); n_bad++;
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); n_bad++; end
    endtask

    task automatic test_single_cycle;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            n_cmp++;
            if (lat !== 1) begin $display("FAIL vec%0d latency: got %0d expected 1", i, lat); n_bad++; end
            n_cmp++;
            if (result !== vecs[i].res) begin
                $display("FAIL vec%0d result: got %b expected %b", i, result, vecs[i].res); n_bad++;
            end
            n_cmp++;
            if (flags !== vecs[i].fl) begin
                $display("FAIL vec%0d flags: got %b expected %b", i, flags, vecs[i].fl); n_bad++;
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL vec%0d back_to_idle: got valid=%b ready=%b expected 0/1", i, out_valid, in_ready);
                n_bad++;
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        run_op(4'h6, 4'h7, 3'b000, lat);   // 6+7 = 1101, N1 Z0 C0 V1 P1
        n_cmp++;
        if (lat !== 1) begin $display("FAIL bp_latency: got %0d expected 1", lat); n_bad++; end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 4'h1;
            b        = 4'h1;
            opcode   = 3'b010;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                $display("FAIL bp_hold%0d handshake: got ready=%b valid=%b expected 0/1", i, in_ready, out_valid);
                n_bad++;
            end
            tick();
            in_valid = 1'b0;
            n_cmp++;
            if (result !== 4'hD || flags !== 5'b10011) begin
                $display("FAIL bp_hold%0d data: got %h/%b expected d/10011", i, result, flags); n_bad++;
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready); n_bad++;
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 4'hD) begin
            $display("FAIL bp_no_accept: got valid=%b result=%h expected 0/d", out_valid, result); n_bad++;
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        out_ready = 1'b0;
        run_op(4'h2, 4'h2, 3'b000, lat);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || result !== 4'h0 || flags !== 5'b0) begin
            $display("FAIL reset_in_done: got %b/%h/%b expected 0/0/00000", out_valid, result, flags); n_bad++;
        end
        run_op(4'h2, 4'h3, 3'b000, lat);
        n_cmp++;
        if (lat !== 1 || result !== 4'h5 || flags !== 5'b00000) begin
            $display("FAIL add_after_reset: got lat=%0d %h/%b expected 1 5/00000", lat, result, flags); n_bad++;
        end
        tick();
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul;
        int lat;
        out_ready = 1'b1;
        run_op(4'h3, 4'h5, 3'b111, lat);
        n_cmp++;
        if (lat !== 5) begin $display("FAIL mul_small_latency: got %0d expected 5", lat); n_bad++; end
        n_cmp++;
        if (result !== 4'hF || flags !== 5'b10000) begin
            $display("FAIL mul_small: got %h/%b expected f/10000", result, flags); n_bad++;
        end
        tick();
        run_op(4'hF, 4'hF, 3'b111, lat);
        n_cmp++;
        if (lat !== 5 || result !== 4'h1 || flags !== 5'b00111) begin
            $display("FAIL mul_overflow: got lat=%0d %h/%b expected 5 1/00111", lat, result, flags); n_bad++;
        end
        tick();
        // Abort two cycles into the multiply.
        in_valid = 1'b1;
        a        = 4'h3;
        b        = 4'h3;
        opcode   = 3'b111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat   = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) lat++;
            tick();
        end
        n_cmp++;
        if (lat !== 0 || result !== 4'h0 || flags !== 5'b0) begin
            $display("FAIL mul_abort: got valid_cycles=%0d %h/%b expected 0 0/00000", lat, result, flags); n_bad++;
        end
        run_op(4'h1, 4'h6, 3'b000, lat);
        n_cmp++;
        if (lat !== 1 || result !== 4'h7 || flags !== 5'b00001) begin
            $display("FAIL add_after_abort: got lat=%0d %h/%b expected 1 7/00001", lat, result, flags); n_bad++;
        end
        tick();
    endtask
`else
    task automatic test_mul_disabled;
        int lat;
        out_ready = 1'b1;
        run_op(4'h5, 4'h3, 3'b111, lat);
        n_cmp++;
        if (lat !== 1) begin $display("FAIL op7_latency: got %0d expected 1", lat); n_bad++; end
        n_cmp++;
        if (result !== 4'h0 || flags !== 5'b01000) begin
            $display("FAIL op7_result: got %h/%b expected 0/01000", result, flags); n_bad++;
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_cycle();
        test_backpressure();
        test_reset_abort();
`ifdef ALU_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
